buffer_link_tx: RTL and testbench

- Read side of the single-entry flit buffers: drains NUM_SRC upstream buffers and forwards one flit at a time onto an outbound link.
- Uses each buffer's rd_en/empty/data_out interface. That buffer updates data_out on the clock edge that samples rd_en, so read latency is 1 cycle.
- Round-robin arbitration across sources. Downstream transfer uses a send/ready handshake.
- Sits between a router input stage's buffers and the neighbour link.

---
 rtl/noc_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/buffer_link_tx.sv | 105 ++++++++++
 tb/tb_buffer_link_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the link-side NoC blocks: FSM encodings, default widths,
// and a pointer-width helper.
package noc_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_e;

    // Ceiling log2 with a minimum of 1 so a single-source pointer still has a bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr,
// wrapping around, so the last winner has lowest priority next time.
module rr_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant_onehot,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_valid
);

    // Two passes: indices above ptr first, then wrap to indices at or below ptr.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        grant_valid  = 1'b0;
        if (en) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!grant_valid && (i > int'(ptr)) && req[i]) begin
                    grant_valid     = 1'b1;
                    grant_onehot[i] = 1'b1;
                    grant_idx       = PTR_W'(i);
                end
            end
            for (int i = 0; i < int'(N); i++) begin
                if (!grant_valid && (i <= int'(ptr)) && req[i]) begin
                    grant_valid     = 1'b1;
                    grant_onehot[i] = 1'b1;
                    grant_idx       = PTR_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/buffer_link_tx.sv
// Drains NUM_SRC single-entry flit buffers round-robin and forwards one flit at a
// time onto the outbound link with a send/ready handshake.
module buffer_link_tx
    import noc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned PTR_W      = clog2_min1(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_empty,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]            src_rd_en,
    output logic                          link_send,
    output logic [DATA_WIDTH-1:0]         link_data,
    input  logic                          link_ready,
    output logic                          busy
);

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       gsel_q, gsel_d;
    logic                   link_send_q, link_send_d;
    logic [DATA_WIDTH-1:0]  link_data_q, link_data_d;

    logic [NUM_SRC-1:0]     grant_onehot;
    logic [PTR_W-1:0]       grant_idx;
    logic                   grant_valid;
    logic [DATA_WIDTH-1:0]  src_words [NUM_SRC];

    for (genvar g = 0; g < int'(NUM_SRC); g++) begin : g_unpack
        assign src_words[g] = src_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Arbitration only happens in IDLE, so rd_en can never fire in FETCH/SEND.
    rr_arbiter #(
        .N     (NUM_SRC),
        .PTR_W (PTR_W)
    ) u_arb (
        .req          (~src_empty),
        .ptr          (rr_ptr_q),
        .en           (state_q == ST_IDLE),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid)
    );

    assign src_rd_en = grant_onehot;
    assign link_send = link_send_q;
    assign link_data = link_data_q;
    assign busy      = (state_q != ST_IDLE);

    // Next-state: read strobe in IDLE, capture buffer output in FETCH, hold in SEND.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gsel_d      = gsel_q;
        link_send_d = link_send_q;
        link_data_d = link_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    rr_ptr_d = grant_idx;
                    gsel_d   = grant_idx;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                link_data_d = src_words[gsel_q];
                link_send_d = 1'b1;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                // link_data is intentionally left holding the last flit.
                if (link_ready) begin
                    link_send_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                link_send_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; rr_ptr resets to the last source so source 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= PTR_W'(NUM_SRC - 1);
            gsel_q      <= '0;
            link_send_q <= 1'b0;
            link_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gsel_q      <= gsel_d;
            link_send_q <= link_send_d;
            link_data_q <= link_data_d;
        end
    end

endmodule

// File: tb/tb_buffer_link_tx.sv
// Self-checking bench for buffer_link_tx: behavioural single-entry buffer sources
// plus a scoreboard of expected link flits in delivery order.
module tb_buffer_link_tx;

    localparam int DW = 64;
    localparam int NS = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NS-1:0]      src_empty = '1;
    logic [DW-1:0]      src_word [NS] = '{default: '0};
    logic [NS*DW-1:0]   src_data;
    logic [NS-1:0]      src_rd_en;
    logic               link_send;
    logic [DW-1:0]      link_data;
    logic               link_ready = 1'b0;
    logic               busy;

    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic [DW-1:0]      src_q [NS][$];
    logic [DW-1:0]      exp_q [$];
    logic [NS-1:0]      rd_seen = '0;

    assign src_data = {src_word[1], src_word[0]};

    buffer_link_tx #(
        .DATA_WIDTH (DW),
        .NUM_SRC    (NS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_empty  (src_empty),
        .src_data   (src_data),
        .src_rd_en  (src_rd_en),
        .link_send  (link_send),
        .link_data  (link_data),
        .link_ready (link_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source buffers: data_out updates on the edge that samples rd_en.
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (rd_seen[i] && src_q[i].size() > 0) begin
                src_word[i] <= src_q[i].pop_front();
            end
        end
    end

    // Empty flags follow queue occupancy.
    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            src_empty[i] <= (src_q[i].size() == 0);
        end
    end

    // Monitor: read-strobe legality and scoreboard compare on each link transfer.
    always @(negedge clk) begin
        #1;
        rd_seen <= src_rd_en;
        if (src_rd_en != '0) begin
            check_eq("rd_onehot", 64'($onehot(src_rd_en)), 64'd1);
            check_eq("rd_to_empty", 64'(src_rd_en & src_empty), 64'd0);
            check_eq("rd_only_idle", 64'(busy), 64'd0);
        end
        if (!rst && link_send && link_ready) begin
            if (exp_q.size() == 0) check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
            else check_eq("link_data_sb", link_data, exp_q.pop_front());
        end
    end

    task automatic sample();
        @(negedge clk);
        #2;
    endtask

    task automatic push(input int s, input logic [DW-1:0] d);
        src_q[s].push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            sample();
            k++;
        end
        check_eq(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_send(input string tag);
        int k;
        k = 0;
        while (!link_send && k < 20) begin
            sample();
            k++;
        end
        check_eq(tag, 64'(link_send), 64'd1);
    endtask

    task automatic wait_rd(input string tag, input logic [NS-1:0] exp);
        int k;
        k = 0;
        while (src_rd_en == '0 && k < 20) begin
            sample();
            k++;
        end
        check_eq(tag, 64'(src_rd_en), 64'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        link_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_link_send", 64'(link_send), 64'd0);
        check_eq("rst_link_data", link_data, 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_rd_en", 64'(src_rd_en), 64'd0);
        rst = 1'b0;
        sample();
        check_eq("idle_rd_en", 64'(src_rd_en), 64'd0);

        // Single flit from source 0
        @(posedge clk);
        #1;
        push(0, 64'hDEAD_BEEF_0000_0001);
        wait_rd("sf_rd_en", 2'b01);
        sample();
        check_eq("sf_rd_one_cycle", 64'(src_rd_en), 64'd0);
        check_eq("sf_fetch_no_send", 64'(link_send), 64'd0);
        sample();
        check_eq("sf_send", 64'(link_send), 64'd1);
        check_eq("sf_data", link_data, 64'hDEAD_BEEF_0000_0001);
        sample();
        check_eq("sf_send_one_cycle", 64'(link_send), 64'd0);
        check_eq("sf_idle", 64'(busy), 64'd0);

        // Backpressure: flit from source 1 held while link_ready is low
        @(posedge clk);
        #1;
        link_ready = 1'b0;
        push(1, 64'h55);
        wait_send("bp_send_seen");
        @(posedge clk);
        #1;
        push(0, 64'h66);
        for (int i = 0; i < 5; i++) begin
            sample();
            check_eq("bp_hold_send", 64'(link_send), 64'd1);
            check_eq("bp_hold_data", link_data, 64'h55);
            check_eq("bp_no_read", 64'(src_rd_en), 64'd0);
        end
        @(posedge clk);
        #1;
        link_ready = 1'b1;
        sample();
        sample();
        check_eq("bp_back_idle", 64'(busy), 64'd0);
        check_eq("bp_next_grant", 64'(src_rd_en), 64'd1);
        check_eq("bp_data_kept", link_data, 64'h55);
        drain("bp_drain");

        // Wrap/priority: lone requester re-granted, then source 0 wins after source 1
        @(posedge clk);
        #1;
        push(1, 64'h31);
        wait_rd("wp_first_src1", 2'b10);
        drain("wp_drain1");
        @(posedge clk);
        #1;
        push(1, 64'h32);
        wait_rd("wp_src1_again", 2'b10);
        drain("wp_drain2");
        @(posedge clk);
        #1;
        push(0, 64'h40);
        push(1, 64'h33);
        wait_rd("wp_src0_after_src1", 2'b01);
        drain("wp_drain3");

        // Round-robin with both sources continuously non-empty
        @(posedge clk);
        #1;
        push(0, 64'h10);
        push(1, 64'h20);
        push(0, 64'h11);
        push(1, 64'h21);
        drain("rr_drain");

        // Reset while a flit is pending in SEND
        @(posedge clk);
        #1;
        link_ready = 1'b0;
        push(0, 64'hABCD);
        wait_send("rs_send_seen");
        check_eq("rs_pending_data", link_data, 64'hABCD);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("rs_send_drop", 64'(link_send), 64'd0);
        check_eq("rs_busy_drop", 64'(busy), 64'd0);
        check_eq("rs_rd_en", 64'(src_rd_en), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        link_ready = 1'b1;
        sample();
        check_eq("rs_data_cleared", link_data, 64'd0);
        for (int i = 0; i < 4; i++) begin
            check_eq("rs_idle", 64'(busy), 64'd0);
            check_eq("rs_no_spurious_rd", 64'(src_rd_en), 64'd0);
            sample();
        end
        check_eq("sb_empty_end", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
